// File: rtl/pulp_clock_div_ctrl.sv
// Sequencer for an XOR-based glitch-free clock divider (divide-by-N, N set at runtime).
// Latency: first divided rising edge 1 cycle after en_i is sampled high; new ratios apply at period end.
// Backpressure: one-entry config slot; cfg_ready_o stays low while a ratio waits for a period boundary.
//
// Ports:
//   clk_i, rst_i             reference clock, synchronous active-high reset
//   en_i                     level-sensitive run request
//   cfg_valid_i/cfg_div_i    new ratio offer; accepted when cfg_ready_o is high
//   cfg_ready_o              config slot free
//   toggle0_o / toggle1_o    rise / fall toggles feeding the external XOR cell
//   bypass_o                 applied ratio below 2, downstream mux selects clk_i
//   active_o                 sequencer is in RUN or DRAIN
//   div_o                    ratio currently applied
module pulp_clock_div_ctrl #(
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 cfg_valid_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  output logic                 cfg_ready_o,
  output logic                 toggle0_o,
  output logic                 toggle1_o,
  output logic                 bypass_o,
  output logic                 active_o,
  output logic [DIV_WIDTH-1:0] div_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  logic [1:0]           state_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 pend_q;
  logic [DIV_WIDTH-1:0] pend_div_q;
  logic                 t0_q;
  logic                 t1_q;

  logic                 eop;
  logic                 hs;
  logic [DIV_WIDTH-1:0] cnt_inc;
  logic [DIV_WIDTH-1:0] half;
  logic [DIV_WIDTH-1:0] next_div;
  logic                 next_div_ok;

  // cnt never exceeds div-1, so with a DIV_WIDTH counter the maximum ratio
  // 2^DIV_WIDTH-1 still fits without wrapping.
  assign eop         = (cnt_q == (div_q - ONE));
  assign cnt_inc     = cnt_q + ONE;
  assign half        = div_q >> 1;
  assign hs          = cfg_valid_i && !pend_q;
  // Ratio that governs the period starting after this EOP.
  assign next_div    = pend_q ? pend_div_q : div_q;
  assign next_div_ok = (next_div > ONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= DEF_DIV;
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      t0_q       <= 1'b0;
      t1_q       <= 1'b0;
    end else begin
      // Handshake only when the slot is empty; applying only when it is full,
      // so the two updates to pend_q below never collide.
      if (hs) begin
        pend_q     <= 1'b1;
        pend_div_q <= cfg_div_i;
      end

      case (state_q)
        ST_IDLE: begin
          // A pending ratio is applied before any start so that the first
          // period always uses the freshly applied value.
          if (pend_q) begin
            div_q  <= pend_div_q;
            pend_q <= 1'b0;
          end else if (en_i && (div_q > ONE)) begin
            state_q <= ST_RUN;
            t0_q    <= ~t0_q;
          end
        end

        ST_RUN, ST_DRAIN: begin
          if (eop) begin
            // Toggles are equal here, so the XOR output is low and it is safe
            // to stop or change ratio.
            if (pend_q) begin
              div_q  <= pend_div_q;
              pend_q <= 1'b0;
            end
            cnt_q <= '0;
            if (en_i && next_div_ok) begin
              state_q <= ST_RUN;
              t0_q    <= ~t0_q;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == half) begin
              t1_q <= ~t1_q;
            end
            state_q <= en_i ? ST_RUN : ST_DRAIN;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign cfg_ready_o = !pend_q;
  assign toggle0_o   = t0_q;
  assign toggle1_o   = t1_q;
  assign div_o       = div_q;
  assign bypass_o    = (div_q < DIV_WIDTH'(2));
  assign active_o    = (state_q == ST_RUN) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_pulp_clock_div_ctrl.sv
// Randomized and directed bench for pulp_clock_div_ctrl against a period-level reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge after each rising edge.
// The config source honours cfg_ready_o; waits on the DUT are bounded by cycle budgets.
module tb_pulp_clock_div_ctrl;

  localparam int W   = 8;
  localparam int DEF = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         cv;
  logic [W-1:0] cd;
  logic         rdy;
  logic         tog0;
  logic         tog1;
  logic         byp;
  logic         act;
  logic [W-1:0] div;

  pulp_clock_div_ctrl #(.DIV_WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .cfg_valid_i (cv),
    .cfg_div_i   (cd),
    .cfg_ready_o (rdy),
    .toggle0_o   (tog0),
    .toggle1_o   (tog1),
    .bypass_o    (byp),
    .active_o    (act),
    .div_o       (div)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: is a period running, how far into it, which ratio, pending slot.
  bit m_act;
  int m_pos;
  int m_div;
  bit m_pend;
  int m_pdiv;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit hs;
    hs = cv && !m_pend;
    if (rst) begin
      m_act = 0; m_pos = 0; m_div = DEF; m_pend = 0; m_pdiv = 0;
      return;
    end
    if (!m_act) begin
      if (m_pend) begin
        m_div = m_pdiv; m_pend = 0;
      end else if (en && m_div >= 2) begin
        m_act = 1; m_pos = 0;
      end
    end else if (m_pos == m_div - 1) begin
      if (m_pend) begin
        m_div = m_pdiv; m_pend = 0;
      end
      m_pos = 0;
      if (!(en && m_div >= 2)) m_act = 0;
    end else begin
      m_pos++;
    end
    if (hs) begin
      m_pend = 1; m_pdiv = int'(cd);
    end
  endfunction

  function automatic int exp_xor();
    return (m_act && (m_pos < m_div / 2)) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("xor",    int'(tog0 ^ tog1), exp_xor());
    chk("active", int'(act), int'(m_act));
    chk("div",    int'(div), m_div);
    chk("bypass", int'(byp), (m_div < 2) ? 1 : 0);
    chk("ready",  int'(rdy), m_pend ? 0 : 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer a ratio and hold it until the handshake completes (bounded).
  task automatic send(input int d);
    bit done;
    done = 0;
    cv = 1; cd = W'(d);
    for (int i = 0; i < 600 && !done; i++) begin
      done = rdy;
      tick();
    end
    cv = 0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  // Advance until the model reaches the given ratio and position (bounded).
  task automatic wait_pos(input int d, input int p);
    int i;
    i = 0;
    while (!(m_act && m_div == d && m_pos == p) && i < 1200) begin
      tick();
      i++;
    end
    if (i >= 1200) chk("wait_timeout", 0, 1);
  endtask

  initial begin
    int hc;
    rst = 1; en = 0; cv = 0; cd = '0;
    m_act = 0; m_pos = 0; m_div = DEF; m_pend = 0; m_pdiv = 0;
    run(2);
    chk("rst_t0", int'(tog0), 0);
    chk("rst_t1", int'(tog1), 0);
    rst = 0;
    run(2);

    // Default ratio 2: first rise right after en_i is sampled.
    en = 1;
    tick();
    chk("first_rise", int'(tog0 ^ tog1), 1);
    run(8);

    // Ratio 5, then 3 offered mid-period.
    send(5);
    wait_pos(5, 1);
    send(3);
    chk("pend_ready_low", int'(rdy), 0);
    run(16);

    // Ratio 4, drop en_i at cnt 1 -> drain, then idle.
    send(4);
    wait_pos(4, 1);
    en = 0;
    run(8);
    chk("drain_idle", int'(act), 0);

    // Ratio 6 running, then bypass ratios, then 7.
    en = 1;
    send(6);
    run(10);
    send(1);
    run(15);
    chk("bypass1", int'(byp), 1);
    send(0);
    run(3);
    chk("bypass0", int'(byp), 1);
    send(7);
    run(24);

    // Maximum ratio: 3 full periods, 127 high cycles each.
    send(255);
    wait_pos(255, 0);
    hc = int'(tog0 ^ tog1);
    for (int i = 0; i < 3 * 255 - 1; i++) begin
      tick();
      hc += int'(tog0 ^ tog1);
    end
    chk("hi255_total", hc, 3 * 127);

    // Reset in the high phase of a ratio-6 period.
    send(6);
    wait_pos(6, 1);
    chk("pre_rst_high", int'(tog0 ^ tog1), 1);
    rst = 1;
    tick();
    chk("midrst_t0", int'(tog0), 0);
    chk("midrst_t1", int'(tog1), 0);
    rst = 0;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0) en = ~en;
      cv = ($urandom_range(5) == 0);
      if ($urandom_range(15) == 0) cd = 8'd255;
      else cd = W'($urandom_range(9));
      if ($urandom_range(999) == 0) rst = 1;
      else rst = 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
